// File: rtl/fill_pkg.sv
// fill_pkg: shared types and screen dimensions for the VGA screen-fill block.
//   fill_state_t : sweep FSM state encoding (IDLE / BEGIN_FILL / END_FILL)
//   SCREEN_W/H   : framebuffer size in pixels (160 x 120)
//   X_MAX/Y_MAX  : last column / last row index
//   X_W/Y_W      : exact coordinate widths; COLOUR_W: colour depth
package fill_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned X_MAX    = SCREEN_W - 1;
    localparam int unsigned Y_MAX    = SCREEN_H - 1;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOUR_W = 3;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        BEGIN_FILL = 2'b10,
        END_FILL   = 2'b11
    } fill_state_t;

endpackage

// File: rtl/fill.sv
// fill: sweeps every pixel of the framebuffer once, column-major (y fastest),
// one pixel per clock, then parks in END_FILL until reset.
// Ports:
//   clk    in  - clock
//   rst    in  - asynchronous active-high reset
//   start  in  - begin a sweep when idle
//   x      out - current column (registered)
//   y      out - current row (registered)
//   colour out - column index modulo 8
//   plot   out - write strobe, high only in BEGIN_FILL
//   done   out - high only in END_FILL
module fill
    import fill_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                done
);

    localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX);

    fill_state_t state;

    // Colour is a slice of the registered column, so it is glitch-free.
    assign colour = x[COLOUR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            plot  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= BEGIN_FILL;
                        x     <= '0;
                        y     <= '0;
                        plot  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                BEGIN_FILL: begin
                    // Terminal compare precedes the increment, so the
                    // counters never wrap past the last pixel.
                    if (x == X_LAST && y == Y_LAST) begin
                        state <= END_FILL;
                        plot  <= 1'b0;
                        done  <= 1'b1;
                    end else if (y == Y_LAST) begin
                        y <= '0;
                        x <= x + 1'b1;
                    end else begin
                        y <= y + 1'b1;
                    end
                end
                END_FILL: begin
                    plot <= 1'b0;
                    done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    x     <= '0;
                    y     <= '0;
                    plot  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/vga_fill_top.sv
// vga_fill_top: board-level wrapper for the screen fill. Conditions the reset
// key, runs the fill sweep continuously and ties off unused board outputs.
// Optional feature macro VGA_ADAPTER_EN: when defined, the sweep drives the
// VGA DAC through vga_adapter; otherwise the DAC outputs are held idle.
// Ports:
//   CLOCK_50        in  - 50 MHz clock
//   KEY[3]          in  - asynchronous active-high reset; KEY[2:0] unused
//   SW              in  - unused
//   LEDR            out - constant 0
//   HEX0..HEX5      out - blank (active-low segments all off)
//   VGA_R/G/B       out - DAC colour (adapter or 0)
//   VGA_HS/VS/CLK   out - DAC sync/clock (adapter or idle levels)
//   VGA_X/VGA_Y     out - current pixel coordinate
//   VGA_COLOUR      out - current pixel colour
//   VGA_PLOT        out - pixel write strobe
module vga_fill_top
    import fill_pkg::*;
(
    input  logic                CLOCK_50,
    input  logic [3:0]          KEY,
    input  logic [9:0]          SW,
    output logic [9:0]          LEDR,
    output logic [6:0]          HEX0,
    output logic [6:0]          HEX1,
    output logic [6:0]          HEX2,
    output logic [6:0]          HEX3,
    output logic [6:0]          HEX4,
    output logic [6:0]          HEX5,
    output logic [7:0]          VGA_R,
    output logic [7:0]          VGA_G,
    output logic [7:0]          VGA_B,
    output logic                VGA_HS,
    output logic                VGA_VS,
    output logic                VGA_CLK,
    output logic [X_W-1:0]      VGA_X,
    output logic [Y_W-1:0]      VGA_Y,
    output logic [COLOUR_W-1:0] VGA_COLOUR,
    output logic                VGA_PLOT
);

    logic w_rst_key;
    logic r_rst_meta;
    logic r_rst_sync;
    logic w_fill_done;
    logic w_unused;

    assign w_rst_key = KEY[3];

    // Assert asynchronously, release two clocks later so the FSM never sees a
    // reset deassertion close to its clock edge.
    always_ff @(posedge CLOCK_50 or posedge w_rst_key) begin
        if (w_rst_key) begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= 1'b1;
        end else begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= r_rst_meta;
        end
    end

    fill fill_inst (
        .clk    (CLOCK_50),
        .rst    (r_rst_sync),
        .start  (1'b1),
        .x      (VGA_X),
        .y      (VGA_Y),
        .colour (VGA_COLOUR),
        .plot   (VGA_PLOT),
        .done   (w_fill_done)
    );

    assign LEDR = '0;
    assign HEX0 = 7'h7F;
    assign HEX1 = 7'h7F;
    assign HEX2 = 7'h7F;
    assign HEX3 = 7'h7F;
    assign HEX4 = 7'h7F;
    assign HEX5 = 7'h7F;

`ifdef VGA_ADAPTER_EN
    logic w_rst_n;
    logic w_vga_blank;
    logic w_vga_sync;

    assign w_rst_n = ~r_rst_sync;

    vga_adapter #(
        .RESOLUTION              ("160x120"),
        .MONOCHROME              ("FALSE"),
        .BITS_PER_COLOUR_CHANNEL (1)
    ) vga_u (
        .resetn    (w_rst_n),
        .clock     (CLOCK_50),
        .colour    (VGA_COLOUR),
        .x         (VGA_X),
        .y         (VGA_Y),
        .plot      (VGA_PLOT),
        .VGA_R     (VGA_R),
        .VGA_G     (VGA_G),
        .VGA_B     (VGA_B),
        .VGA_HS    (VGA_HS),
        .VGA_VS    (VGA_VS),
        .VGA_BLANK (w_vga_blank),
        .VGA_SYNC  (w_vga_sync),
        .VGA_CLK   (VGA_CLK)
    );

    assign w_unused = ^{KEY[2:0], SW, w_fill_done, w_vga_blank, w_vga_sync};
`else
    assign VGA_R   = '0;
    assign VGA_G   = '0;
    assign VGA_B   = '0;
    assign VGA_HS  = 1'b1;
    assign VGA_VS  = 1'b1;
    assign VGA_CLK = 1'b0;

    assign w_unused = ^{KEY[2:0], SW, w_fill_done};
`endif

endmodule

// File: tb/tb_vga_fill_top.sv
// tb_vga_fill_top: directed/randomized bench for vga_fill_top. A reference
// model derives the expected pixel for sweep cycle k as (k / 120, k % 120)
// with colour x mod 8, and a coverage array confirms each pixel appears once.
module tb_vga_fill_top;

    localparam int W = 160;
    localparam int H = 120;

    logic       CLOCK_50;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [9:0] LEDR;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_CLK;
    logic [7:0] VGA_X;
    logic [6:0] VGA_Y;
    logic [2:0] VGA_COLOUR;
    logic       VGA_PLOT;

    int n_tests = 0;
    int n_fail  = 0;

    int seen [W][H];

    `define CHK(tag, obs, exp) \
        begin \
            n_tests++; \
            assert ((obs) === (exp)) else begin \
                n_fail++; \
                $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
            end \
        end

    vga_fill_top dut (
        .CLOCK_50   (CLOCK_50),
        .KEY        (KEY),
        .SW         (SW),
        .LEDR       (LEDR),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3),
        .HEX4       (HEX4),
        .HEX5       (HEX5),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .VGA_CLK    (VGA_CLK),
        .VGA_X      (VGA_X),
        .VGA_Y      (VGA_Y),
        .VGA_COLOUR (VGA_COLOUR),
        .VGA_PLOT   (VGA_PLOT)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Advance one clock, toggling the unused inputs randomly; KEY[3] is kept.
    task automatic step();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        SW       = 10'($urandom);
        KEY[2:0] = 3'($urandom);
    endtask

    initial begin
        int k;
        int bad;
        int both;
        int dup;
        int hold_bad;
        int hold_n;
        int target;
        bit reached;
        int ex;
        int ey;

        KEY = 4'b1000;
        SW  = '0;
        repeat (3) step();

        // Reset state
        `CHK("rst_state", dut.fill_inst.state, 2'b00)
        `CHK("rst_x", VGA_X, 8'd0)
        `CHK("rst_y", VGA_Y, 7'd0)
        `CHK("rst_plot", VGA_PLOT, 1'b0)
        `CHK("rst_done", dut.fill_inst.done, 1'b0)
        `CHK("rst_colour", VGA_COLOUR, 3'd0)
        `CHK("ledr", LEDR, 10'd0)
        `CHK("hex", {HEX0, HEX1, HEX2, HEX3, HEX4, HEX5}, {6{7'h7F}})
`ifndef VGA_ADAPTER_EN
        `CHK("vga_tie", {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_CLK}, {24'd0, 3'b110})
`endif

        // Release between edges; BEGIN_FILL appears only on the third edge.
        KEY[3] = 1'b0;
        step();
        `CHK("e1_state", dut.fill_inst.state, 2'b00)
        step();
        `CHK("e2_state", dut.fill_inst.state, 2'b00)
        `CHK("e2_plot", VGA_PLOT, 1'b0)
        step();
        `CHK("e3_state", dut.fill_inst.state, 2'b10)
        `CHK("e3_x", VGA_X, 8'd0)
        `CHK("e3_y", VGA_Y, 7'd0)
        `CHK("e3_plot", VGA_PLOT, 1'b1)
        `CHK("e3_done", dut.fill_inst.done, 1'b0)
        `CHK("e3_colour", VGA_COLOUR, 3'd0)

        // Full sweep against the reference model
        for (int i = 0; i < W; i++)
            for (int j = 0; j < H; j++)
                seen[i][j] = 0;
        k    = 0;
        bad  = 0;
        both = 0;
        for (int c = 0; c < 20000 && dut.fill_inst.done !== 1'b1; c++) begin
            if (VGA_PLOT === 1'b1) begin
                ex = k / H;
                ey = k % H;
                if (int'(VGA_X) != ex || int'(VGA_Y) != ey || int'(VGA_COLOUR) != ex % 8)
                    bad++;
                if (int'(VGA_X) < W && int'(VGA_Y) < H)
                    seen[VGA_X][VGA_Y]++;
                else
                    bad++;
                if (k == 121) begin
                    `CHK("k121_x", VGA_X, 8'd1)
                    `CHK("k121_y", VGA_Y, 7'd1)
                    `CHK("k121_colour", VGA_COLOUR, 3'd1)
                    `CHK("k121_plot", VGA_PLOT, 1'b1)
                end
                k++;
            end
            if (VGA_PLOT === 1'b1 && dut.fill_inst.done === 1'b1)
                both++;
            step();
        end
        dup = 0;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < H; j++)
                if (seen[i][j] != 1)
                    dup++;
        `CHK("fill_done_reached", dut.fill_inst.done, 1'b1)
        `CHK("plot_count", k, W * H)
        `CHK("pixel_model_errs", bad, 0)
        `CHK("pixel_coverage_errs", dup, 0)
        `CHK("plot_and_done", both, 0)
        `CHK("end_state", dut.fill_inst.state, 2'b11)
        `CHK("end_x", VGA_X, 8'd159)
        `CHK("end_y", VGA_Y, 7'd119)
        `CHK("end_plot", VGA_PLOT, 1'b0)

        // END_FILL is absorbing
        hold_n   = 1000 + int'($urandom_range(0, 200));
        hold_bad = 0;
        for (int c = 0; c < hold_n; c++) begin
            step();
            if (dut.fill_inst.state !== 2'b11 || VGA_X !== 8'd159 || VGA_Y !== 7'd119 ||
                dut.fill_inst.done !== 1'b1 || VGA_PLOT !== 1'b0)
                hold_bad++;
        end
        `CHK("hold_errs", hold_bad, 0)
        `CHK("hold_state", dut.fill_inst.state, 2'b11)
        `CHK("hold_done", dut.fill_inst.done, 1'b1)

        // Restart, then reset asynchronously mid-sweep
        KEY[3] = 1'b1;
        step();
        step();
        KEY[3] = 1'b0;
        repeat (3) step();
        `CHK("restart_state", dut.fill_inst.state, 2'b10)
        target  = int'($urandom_range(20, 150));
        reached = 1'b0;
        for (int c = 0; c < 20000 && !reached; c++) begin
            if (int'(VGA_X) == target)
                reached = 1'b1;
            else
                step();
        end
        `CHK("mid_reached", reached, 1'b1)
        #3;
        KEY[3] = 1'b1;
        #1;
        `CHK("async_state", dut.fill_inst.state, 2'b00)
        `CHK("async_x", VGA_X, 8'd0)
        `CHK("async_y", VGA_Y, 7'd0)
        `CHK("async_plot", VGA_PLOT, 1'b0)
        `CHK("async_done", dut.fill_inst.done, 1'b0)
        `CHK("async_before_edge", CLOCK_50, 1'b0)
        step();
        KEY[3] = 1'b0;
        step();
        step();
        `CHK("re_e2_state", dut.fill_inst.state, 2'b00)
        step();
        `CHK("re_e3_state", dut.fill_inst.state, 2'b10)
        `CHK("re_e3_x", VGA_X, 8'd0)
        `CHK("re_e3_y", VGA_Y, 7'd0)
        `CHK("re_e3_plot", VGA_PLOT, 1'b1)
        step();
        `CHK("re_next_y", VGA_Y, 7'd1)
        `CHK("re_next_x", VGA_X, 8'd0)

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
